// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  localparam logic [1:0]  PAR_NONE     = 2'b00;
  localparam logic [1:0]  PAR_EVEN     = 2'b01;
  localparam logic [1:0]  PAR_ODD      = 2'b10;
  localparam logic [15:0] BAUD_DIV_MIN = 16'd4;

  // 2'b11 is an alias for no parity, so only the two explicit codes enable it
  function automatic logic par_en(input logic [1:0] sel);
    return sel == PAR_EVEN || sel == PAR_ODD;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two FIFO with a registered head word that holds when empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             full, do_push, do_pop;

  assign full     = count_q == (AW+1)'(DEPTH);
  assign empty    = count_q == '0;
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & ~do_push;
  assign rdata    = rdata_q;

  // Next pointers/count; the head register loads the incoming word when it becomes the only entry
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    rdata_d  = (do_push && count_q == (AW+1)'(do_pop)) ? wdata :
               (do_pop && count_q > (AW+1)'(1))         ? mem_q[rd_ptr_d] : rdata_q;
  end

  // Storage array needs no reset: unwritten slots are never presented
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointer, count and head state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with mid-bit sampling, parity/stop checks and a byte FIFO
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] baud_div,
  input  logic [1:0]  parity_sel,
  input  logic        rxd,
  input  logic        ren,
  output logic [7:0]  rdata,
  output logic        rvalid,
  output logic        busy,
  output logic        frame_err,
  output logic        parity_err,
  output logic        overrun
);

  logic        meta_q, rxd_s_q;
  rx_state_t   state_q, state_d;
  logic [15:0] cnt_q, cnt_d, div_q, div_d, half_m1;
  logic [1:0]  par_q, par_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        perr_q, perr_d, push_q, push_d, ferr_q, ferr_d, pe_q, pe_d;
  logic        tick, fifo_empty;

  assign half_m1    = (div_q >> 1) - 16'd1;
  assign tick       = cnt_q == div_q - 16'd1;
  assign busy       = state_q != IDLE;
  assign rvalid     = ~fifo_empty;
  assign frame_err  = ferr_q;
  assign parity_err = pe_q;

  // Two-flop synchroniser, idle-high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {rxd_s_q, meta_q} <= 2'b11;
    else        {rxd_s_q, meta_q} <= {meta_q, rxd};
  end

  // Frame sequencing: the bit timer restarts at each sample so every later sample lands mid-bit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    div_d   = div_q;
    par_d   = par_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    push_d  = 1'b0;
    ferr_d  = 1'b0;
    pe_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxd_s_q) begin
          state_d = START;
          div_d   = baud_div < BAUD_DIV_MIN ? BAUD_DIV_MIN : baud_div;
          par_d   = parity_sel;
          perr_d  = 1'b0;
          bit_d   = '0;
        end
      end
      START: if (cnt_q == half_m1) begin
        cnt_d   = '0;
        state_d = rxd_s_q ? IDLE : DATA;
      end
      DATA: if (tick) begin
        cnt_d   = '0;
        shift_d = {rxd_s_q, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = par_en(par_q) ? PARITY : STOP;
      end
      PARITY: if (tick) begin
        cnt_d   = '0;
        perr_d  = (^shift_q ^ rxd_s_q) != (par_q == PAR_ODD);
        state_d = STOP;
      end
      STOP: if (tick) begin
        state_d = IDLE;
        ferr_d  = ~rxd_s_q;
        pe_d    = perr_q;
        push_d  = rxd_s_q & ~perr_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Receiver state and registered result pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= BAUD_DIV_MIN;
      par_q   <= PAR_NONE;
      bit_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      push_q  <= 1'b0;
      ferr_q  <= 1'b0;
      pe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      par_q   <= par_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      push_q  <= push_d;
      ferr_q  <= ferr_d;
      pe_q    <= pe_d;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_q),
    .wdata    (shift_q),
    .pop      (ren),
    .rdata    (rdata),
    .empty    (fifo_empty),
    .overflow (overrun)
  );

endmodule
